bip_debug_unit: RTL and testbench

BIP_DEBUG_UNIT -- requirements
Module: bip_debug_unit

---
 rtl/bip_debug_unit.sv | 166 ++++++++++++++++
 tb/tb_bip_debug_unit.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_debug_unit.sv
// UART-driven run/step/dump debug controller for the BIP processor.
// Define BIP_DBG_CYCLE_CNT_EN to add a saturating cycle counter to the dump frame.
module bip_debug_unit #(
  parameter int AB = 11,
  parameter int DB = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_done,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  input  logic          tx_done,
  input  logic          cpu_halt,
  input  logic [AB-1:0] cpu_pc,
  input  logic [DB-1:0] cpu_acc,
  output logic          cpu_en,
  output logic          cpu_clear,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STEP,
    DUMP_LOAD,
    DUMP_SEND,
    DUMP_WAIT
  } state_e;

  localparam logic [7:0] CMD_R = 8'h72;
  localparam logic [7:0] CMD_S = 8'h73;
  localparam logic [7:0] CMD_D = 8'h64;
  localparam logic [7:0] CMD_C = 8'h63;
  localparam logic [7:0] CMD_H = 8'h68;

`ifdef BIP_DBG_CYCLE_CNT_EN
  localparam int NB = 6;
`else
  localparam int NB = 4;
`endif
  localparam int FW = 8 * NB;
  localparam logic [2:0] LAST = 3'(NB - 1);

  state_e        state_q;
  logic [FW-1:0] frame_q;
  logic [2:0]    left_q;
  logic [7:0]    tx_data_q;
  logic          tx_start_q;
  logic          cpu_en_q;
  logic          cpu_clear_q;
  logic          busy_q;
  logic [15:0]   pc_ext;
  logic [FW-1:0] snap;

  assign pc_ext = 16'(cpu_pc);

`ifdef BIP_DBG_CYCLE_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        cnt_clr;

  assign cnt_clr = (state_q == IDLE) && rx_done && (rx_data == CMD_C);

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)
      cnt_d = '0;
    else if (cpu_en_q && !cpu_halt && (cnt_q != 16'hFFFF))
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign snap = {pc_ext, cpu_acc, cnt_q};
`else
  assign snap = {pc_ext, cpu_acc};
`endif

  // Outputs are registered alongside each transition so they track the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      left_q      <= '0;
      tx_data_q   <= 8'h00;
      tx_start_q  <= 1'b0;
      cpu_en_q    <= 1'b0;
      cpu_clear_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      tx_start_q  <= 1'b0;
      cpu_clear_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rx_done) begin
            unique case (1'b1)
              rx_data == CMD_R: begin
                state_q  <= cpu_halt ? DUMP_LOAD : RUN;
                cpu_en_q <= !cpu_halt;
                busy_q   <= 1'b1;
              end
              rx_data == CMD_S: begin
                state_q  <= STEP;
                cpu_en_q <= 1'b1;
                busy_q   <= 1'b1;
              end
              rx_data == CMD_D: begin
                state_q <= DUMP_LOAD;
                busy_q  <= 1'b1;
              end
              rx_data == CMD_C: cpu_clear_q <= 1'b1;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cpu_halt || (rx_done && rx_data == CMD_H)) begin
            state_q  <= DUMP_LOAD;
            cpu_en_q <= 1'b0;
          end
        end
        STEP: begin
          state_q  <= DUMP_LOAD;
          cpu_en_q <= 1'b0;
        end
        DUMP_LOAD: begin
          frame_q <= snap;
          left_q  <= LAST;
          state_q <= DUMP_SEND;
        end
        DUMP_SEND: begin
          tx_data_q  <= frame_q[FW-1 -: 8];
          tx_start_q <= 1'b1;
          frame_q    <= {frame_q[FW-9:0], 8'h00};
          state_q    <= DUMP_WAIT;
        end
        DUMP_WAIT: begin
          if (tx_done) begin
            if (left_q == 3'd0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              left_q  <= left_q - 3'd1;
              state_q <= DUMP_SEND;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          cpu_en_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign cpu_en    = cpu_en_q;
  assign cpu_clear = cpu_clear_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bip_debug_unit.sv
// Randomized self-checking bench for bip_debug_unit.
// Honours BIP_DBG_CYCLE_CNT_EN to expect 6- or 4-byte dump frames.
module tb_bip_debug_unit;

`ifdef BIP_DBG_CYCLE_CNT_EN
  localparam int NB = 6;
`else
  localparam int NB = 4;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done;
  logic        cpu_halt;
  logic [10:0] cpu_pc;
  logic [15:0] cpu_acc;
  logic        cpu_en;
  logic        cpu_clear;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  bip_debug_unit #(.AB(11), .DB(16)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_done(rx_done),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .cpu_halt(cpu_halt), .cpu_pc(cpu_pc), .cpu_acc(cpu_acc),
    .cpu_en(cpu_en), .cpu_clear(cpu_clear), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: counter adds cycles saturating at 0xFFFF.
  function automatic void cnt_add(input int n);
    exp_cnt = (exp_cnt + n > 65535) ? 65535 : exp_cnt + n;
  endfunction

  function automatic void mk_frame(input logic [15:0] pc, input logic [15:0] acc,
                                   input logic [15:0] cnt, output logic [7:0] f [6]);
    f[0] = pc[15:8];  f[1] = pc[7:0];
    f[2] = acc[15:8]; f[3] = acc[7:0];
    f[4] = cnt[15:8]; f[5] = cnt[7:0];
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rx_data = 8'h72;
    rx_done = 1'b1;
    tx_done = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rx_done = 1'b0;
    tx_done = 1'b0;
    exp_cnt = 0;
  endtask

  // Acts as the UART transmitter; also throws command bytes at the DUT mid-dump.
  task automatic dump_collect(output int n, output logic [7:0] got [6], output bit to);
    int  wait_c;
    bit  pend;
    logic [7:0] cmds [5];
    cmds[0] = 8'h72; cmds[1] = 8'h73; cmds[2] = 8'h64;
    cmds[3] = 8'h63; cmds[4] = 8'h68;
    for (int i = 0; i < 6; i++) got[i] = 'x;
    n = 0; to = 1'b1; pend = 1'b0; wait_c = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      tx_done = 1'b0;
      rx_done = 1'b0;
      if (tx_start) begin
        if (n < 6) got[n] = tx_data;
        n++;
        pend = 1'b1;
        wait_c = $urandom_range(1, 4);
      end else if (pend) begin
        wait_c--;
        if (wait_c == 0) begin
          tx_done = 1'b1;
          pend = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          rx_data = cmds[$urandom_range(0, 4)];
          rx_done = 1'b1;
        end
      end else if (!busy) begin
        to = 1'b0;
        break;
      end
    end
    tx_done = 1'b0;
    rx_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en got %b exp 0", cpu_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b exp 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
    checks++; if (cpu_clear !== 1'b0) begin errors++; $display("FAIL reset_cpu_clear got %b exp 0", cpu_clear); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_prio_busy got %b exp 0", busy); end
  endtask

  task automatic test_dump();
    int n; bit to; logic [7:0] got [6]; logic [7:0] ef [6];
    cpu_pc = 11'h005; cpu_acc = 16'h1234;
    send_byte(8'h64);
    dump_collect(n, got, to);
    mk_frame(16'h0005, 16'h1234, 16'(exp_cnt), ef);
    checks++; if (to || n != NB) begin errors++; $display("FAIL dump_len got %0d exp %0d to %0d", n, NB, to); end
    for (int i = 0; i < NB; i++) begin
      checks++; if (got[i] !== ef[i]) begin errors++; $display("FAIL dump_byte%0d got %h exp %h", i, got[i], ef[i]); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dump_busy got %b exp 0", busy); end
  endtask

  task automatic test_run();
    int n; int en_cnt; bit to; logic [7:0] got [6]; logic [7:0] ef [6];
    cpu_halt = 1'b0; cpu_pc = 11'h00A; cpu_acc = 16'($urandom);
    send_byte(8'h72);
    en_cnt = cpu_en ? 1 : 0;
    repeat (10) begin
      @(negedge clk);
      if (cpu_en) en_cnt++;
    end
    cpu_halt = 1'b1;
    cnt_add(10);
    @(negedge clk);
    checks++; if (en_cnt != 11) begin errors++; $display("FAIL run_en_cycles got %0d exp 11", en_cnt); end
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL run_en_drop got %b exp 0", cpu_en); end
    dump_collect(n, got, to);
    mk_frame(16'h000A, cpu_acc, 16'(exp_cnt), ef);
    checks++; if (to || n != NB) begin errors++; $display("FAIL run_len got %0d exp %0d to %0d", n, NB, to); end
    for (int i = 0; i < NB; i++) begin
      checks++; if (got[i] !== ef[i]) begin errors++; $display("FAIL run_byte%0d got %h exp %h", i, got[i], ef[i]); end
    end
    cpu_halt = 1'b0;
  endtask

  task automatic test_run_halted();
    int n; bit to; logic [7:0] got [6]; logic [7:0] ef [6];
    cpu_halt = 1'b1; cpu_pc = 11'($urandom); cpu_acc = 16'($urandom);
    send_byte(8'h72);
    checks++; if (cpu_en !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL halted_r en %b busy %b exp 0 1", cpu_en, busy);
    end
    dump_collect(n, got, to);
    mk_frame(16'(cpu_pc), cpu_acc, 16'(exp_cnt), ef);
    checks++; if (to || n != NB) begin errors++; $display("FAIL halted_len got %0d exp %0d to %0d", n, NB, to); end
    for (int i = 0; i < NB; i++) begin
      checks++; if (got[i] !== ef[i]) begin errors++; $display("FAIL halted_byte%0d got %h exp %h", i, got[i], ef[i]); end
    end
    cpu_halt = 1'b0;
  endtask

  task automatic test_step();
    int n; bit to; logic [7:0] got [6]; logic [7:0] ef [6];
    do_reset();
    cpu_halt = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cpu_pc = 11'($urandom); cpu_acc = 16'($urandom);
      send_byte(8'h73);
      checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL step%0d_en_on got %b exp 1", k, cpu_en); end
      @(negedge clk);
      checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL step%0d_en_off got %b exp 0", k, cpu_en); end
      cnt_add(1);
      dump_collect(n, got, to);
      mk_frame(16'(cpu_pc), cpu_acc, 16'(exp_cnt), ef);
      checks++; if (to || n != NB) begin errors++; $display("FAIL step%0d_len got %0d exp %0d", k, n, NB); end
      for (int i = 0; i < NB; i++) begin
        checks++; if (got[i] !== ef[i]) begin errors++; $display("FAIL step%0d_byte%0d got %h exp %h", k, i, got[i], ef[i]); end
      end
    end
  endtask

  task automatic test_clear();
    int n; bit to; logic [7:0] got [6]; logic [7:0] ef [6];
    send_byte(8'h63);
    exp_cnt = 0;
    checks++; if (cpu_clear !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL clear_pulse clr %b busy %b exp 1 0", cpu_clear, busy);
    end
    @(negedge clk);
    checks++; if (cpu_clear !== 1'b0) begin errors++; $display("FAIL clear_width got %b exp 0", cpu_clear); end
    cpu_pc = 11'($urandom); cpu_acc = 16'($urandom);
    send_byte(8'h64);
    dump_collect(n, got, to);
    mk_frame(16'(cpu_pc), cpu_acc, 16'(exp_cnt), ef);
    checks++; if (to || n != NB) begin errors++; $display("FAIL clear_len got %0d exp %0d", n, NB); end
    for (int i = 0; i < NB; i++) begin
      checks++; if (got[i] !== ef[i]) begin errors++; $display("FAIL clear_byte%0d got %h exp %h", i, got[i], ef[i]); end
    end
  endtask

  task automatic test_ignore();
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    checks++; if (busy !== 1'b0 || tx_start !== 1'b0) begin
      errors++; $display("FAIL idle_txdone busy %b start %b exp 0 0", busy, tx_start);
    end
    send_byte(8'h68);
    checks++; if (busy !== 1'b0 || cpu_en !== 1'b0) begin
      errors++; $display("FAIL idle_h busy %b en %b exp 0 0", busy, cpu_en);
    end
  endtask

  task automatic test_halt_cmd_reset();
    int m; int starts; int hold; logic [7:0] ef [6]; bit seen;
    cpu_halt = 1'b0; cpu_pc = 11'($urandom); cpu_acc = 16'($urandom);
    m = $urandom_range(3, 10);
    send_byte(8'h72);
    repeat (m) @(negedge clk);
    send_byte(8'h41);
    checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL hcmd_ignore_en got %b exp 1", cpu_en); end
    send_byte(8'h68);
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL hcmd_en_drop got %b exp 0", cpu_en); end
    cnt_add(m + 4);
    mk_frame(16'(cpu_pc), cpu_acc, 16'(exp_cnt), ef);
    starts = 0; hold = 0;
    for (int i = 0; i < 300 && starts < 3; i++) begin
      @(negedge clk);
      tx_done = 1'b0;
      if (tx_start) begin
        if (starts < 2) begin
          checks++;
          if (tx_data !== ef[starts]) begin
            errors++; $display("FAIL hcmd_byte%0d got %h exp %h", starts, tx_data, ef[starts]);
          end
        end
        starts++;
        hold = 2;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) tx_done = 1'b1;
      end
    end
    checks++; if (starts != 3) begin errors++; $display("FAIL hcmd_starts got %0d exp 3", starts); end
    reset = 1'b1;
    tx_done = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tx_done = 1'b0;
    exp_cnt = 0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (tx_start || busy) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL abort_quiet got activity 1 exp 0"); end
  endtask

  task automatic test_random();
    int n; int op; int cyc; bit to; logic [7:0] got [6]; logic [7:0] ef [6];
    logic [7:0] b;
    for (int k = 0; k < 12; k++) begin
      op = $urandom_range(0, 4);
      cpu_pc = 11'($urandom); cpu_acc = 16'($urandom);
      cpu_halt = 1'b0;
      if (op == 3) begin
        send_byte(8'h63);
        exp_cnt = 0;
        checks++; if (cpu_clear !== 1'b1) begin errors++; $display("FAIL rnd%0d_clear got %b exp 1", k, cpu_clear); end
      end else if (op == 4) begin
        do b = 8'($urandom);
        while (b == 8'h72 || b == 8'h73 || b == 8'h64 || b == 8'h63);
        send_byte(b);
        checks++; if (busy !== 1'b0 || cpu_en !== 1'b0) begin
          errors++; $display("FAIL rnd%0d_ignore busy %b en %b exp 0 0", k, busy, cpu_en);
        end
      end else begin
        if (op == 0) send_byte(8'h64);
        else if (op == 1) begin
          send_byte(8'h73);
          cnt_add(1);
        end else begin
          cyc = $urandom_range(0, 12);
          send_byte(8'h72);
          repeat (cyc) @(negedge clk);
          cpu_halt = 1'b1;
          cnt_add(cyc);
        end
        dump_collect(n, got, to);
        mk_frame(16'(cpu_pc), cpu_acc, 16'(exp_cnt), ef);
        checks++; if (to || n != NB) begin errors++; $display("FAIL rnd%0d_len got %0d exp %0d", k, n, NB); end
        for (int i = 0; i < NB; i++) begin
          checks++; if (got[i] !== ef[i]) begin errors++; $display("FAIL rnd%0d_byte%0d got %h exp %h", k, i, got[i], ef[i]); end
        end
      end
    end
    cpu_halt = 1'b0;
  endtask

`ifdef BIP_DBG_CYCLE_CNT_EN
  task automatic test_saturate();
    int n; bit to; logic [7:0] got [6];
    do_reset();
    cpu_halt = 1'b0;
    send_byte(8'h72);
    repeat (65540) @(negedge clk);
    cpu_halt = 1'b1;
    cnt_add(65540);
    dump_collect(n, got, to);
    checks++; if (to || {got[4], got[5]} !== 16'(exp_cnt)) begin
      errors++; $display("FAIL sat_run got %h%h exp %h", got[4], got[5], 16'(exp_cnt));
    end
    cpu_halt = 1'b0;
    send_byte(8'h73);
    cnt_add(1);
    dump_collect(n, got, to);
    checks++; if (to || {got[4], got[5]} !== 16'(exp_cnt)) begin
      errors++; $display("FAIL sat_step got %h%h exp %h", got[4], got[5], 16'(exp_cnt));
    end
  endtask
`endif

  initial begin
    reset = 1'b0; rx_data = 8'h00; rx_done = 1'b0; tx_done = 1'b0;
    cpu_halt = 1'b0; cpu_pc = '0; cpu_acc = '0;
    test_reset();
    test_dump();
    test_run();
    test_run_halted();
    test_step();
    test_clear();
    test_ignore();
    test_halt_cmd_reset();
    test_random();
`ifdef BIP_DBG_CYCLE_CNT_EN
    test_saturate();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
